seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the switch-to-seven-segment display driver: watches the multiplexed display bus (segments hex, anodes AN) and rebuilds the 8 displayed hex digits as a 32-bit word.
- Used as a loopback checker and readback block beside the display driver on the same board design.
- Filters scan transitions with a stability counter, decodes segment patterns to nibbles, and stores each digit per anode position.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples of {AN,hex} required before capture; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- hex  in  7  segment bus {g,f,e,d,c,b,a}, active low (0 = segment lit).
- AN  in  8  anode selects, active low; exactly one low bit = valid digit select.
- digits  out  32  captured digits; nibble i = digit on AN[i].
- digit_valid  out  8  bit i set when nibble i holds a successfully decoded value.
- upd  out  1  one-cycle pulse on each successful capture.
- upd_idx  out  3  index of digit written; meaningful while upd=1, else holds last value.
- err  out  1  one-cycle pulse when a stable, valid anode select carries an undecodable pattern.
- frame_done  out  1  one-cycle pulse when all 8 positions have been captured since the previous frame_done or reset.

Behaviour:
- Reset (async assert, sync release): digits=0, digit_valid=0, upd=0, upd_idx=0, err=0, frame_done=0, seen mask=0, stability count=0, sample regs s_an=8'hFF, s_hex=7'h7F, FSM=IDLE.
- Input stage: {AN,hex} registered every clock into {s_an,s_hex}. Stability count: 0 when the new sample differs from the previous one, otherwise increment, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: s_an not one-hot-low (all high or 2+ low). Count forced to 0. Go to SETTLE when s_an is one-hot-low.
  - SETTLE: counting. Go to CAPTURE when the count reaches STABLE_CYCLES-1, meaning STABLE_CYCLES identical samples. Return to IDLE on an invalid s_an. Restart counting on any change.
  - CAPTURE: single cycle. Decode and write, then go to HOLD.
  - HOLD: no further capture while the sample is unchanged. On any change, go to SETTLE (one-hot AN) or IDLE.
- Latency: an input pair first present at edge k gives upd high during the cycle after edge k+STABLE_CYCLES. Outputs are registered.
- Decode: standard active-low 0-F patterns.
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit).
  - Any other pattern is invalid.
- Valid capture: digits[4i+3:4i]=value, digit_valid[i]=1, upd=1, upd_idx=i, seen[i]=1.
- Invalid capture: digits nibble unchanged, digit_valid[i]=0, err=1, upd=0, seen unchanged.
- frame_done: asserted in the same cycle as the upd that makes seen=8'hFF; seen clears to 0 in that cycle. Recapturing an already-seen digit refreshes the value only, with no frame_done.
- Only one capture per cycle, so upd and err are never both high.
- Reset mid-SETTLE or mid-frame: partial count and seen mask are discarded. The next frame needs all 8 digits again.

Optional Feature:
- SEG7_ERR_CNT_EN defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments on every err pulse and saturates at 8'hFF.
  - Also adds input err_clr (1 bit, sync, active high); err_clr wins over a simultaneous increment.
- Undefined: no err_cnt or err_clr ports; err pulse only.

Test Plan:
- Reset check: assert rst_n=0 mid-run with AN=8'hFE held -> all outputs 0 immediately; no upd until 4 stable samples after release.
- Single digit: AN=8'hFE, hex=7'h40 held 10 clocks (STABLE_CYCLES=4) -> exactly one upd, 5 clocks after the change, upd_idx=0, digits[3:0]=0, digit_valid=8'h01.
- Glitch reject: AN=8'hFD, hex=7'h12 held 3 clocks, then AN=8'hFB -> no upd for index 1. Then hold hex=7'h12 on 8'hFB for 4+ clocks -> upd_idx=2, digits[11:8]=5.
- Bad select/pattern:
  - AN=8'hFC held 20 clocks -> no upd/err.
  - AN=8'hFE, hex=7'h7F held -> single err, digit_valid[0]=0, digits[3:0] unchanged; with SEG7_ERR_CNT_EN, err_cnt=1.
- Full frame: scan AN[i] low with digit i (i=0..7), 6 clocks each -> 8 upd pulses, frame_done coincident with the 8th, digits=32'h76543210, digit_valid=8'hFF. A second identical scan gives exactly one more frame_done.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: rebuilds the 8 hex digits shown on a multiplexed,
// active-low seven-segment bus by filtering scan transitions, decoding
// segment patterns and storing each digit at its anode position.
// Optional build macro SEG7_ERR_CNT_EN adds a saturating error counter
// (err_cnt) with a synchronous clear input (err_clr).
module seg7_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  hex,
  input  logic [7:0]  AN,
`ifdef SEG7_ERR_CNT_EN
  input  logic        err_clr,
  output logic [7:0]  err_cnt,
`endif
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        upd,
  output logic [2:0]  upd_idx,
  output logic        err,
  output logic        frame_done
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [7:0]    s_an;
  logic [6:0]    s_hex;
  logic [CW-1:0] cnt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [7:0]    seen;
  logic [7:0]    seen_set;
  logic          an_ok;
  logic [2:0]    an_idx;
  logic          changed;
  logic          capture;
  logic [4:0]    dec;

  // Active-low pattern to {valid, nibble}
  function automatic logic [4:0] decode7(input logic [6:0] p);
    case (p)
      7'h40:   decode7 = {1'b1, 4'h0};
      7'h79:   decode7 = {1'b1, 4'h1};
      7'h24:   decode7 = {1'b1, 4'h2};
      7'h30:   decode7 = {1'b1, 4'h3};
      7'h19:   decode7 = {1'b1, 4'h4};
      7'h12:   decode7 = {1'b1, 4'h5};
      7'h02:   decode7 = {1'b1, 4'h6};
      7'h78:   decode7 = {1'b1, 4'h7};
      7'h00:   decode7 = {1'b1, 4'h8};
      7'h10:   decode7 = {1'b1, 4'h9};
      7'h08:   decode7 = {1'b1, 4'hA};
      7'h03:   decode7 = {1'b1, 4'hB};
      7'h46:   decode7 = {1'b1, 4'hC};
      7'h21:   decode7 = {1'b1, 4'hD};
      7'h06:   decode7 = {1'b1, 4'hE};
      7'h0E:   decode7 = {1'b1, 4'hF};
      default: decode7 = 5'h00;
    endcase
  endfunction

  // Select validity, selected position, sample change and pattern decode
  always_comb begin
    an_ok   = $onehot(~s_an);
    an_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!s_an[i]) an_idx = 3'(i);
    end
    changed  = ({AN, hex} != {s_an, s_hex});
    dec      = decode7(s_hex);
    seen_set = seen | (8'b1 << an_idx);
  end

  // Input sample stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an  <= 8'hFF;
      s_hex <= 7'h7F;
    end else begin
      s_an  <= AN;
      s_hex <= hex;
    end
  end

  // Stability counter: restarts on any change, saturates at STABLE_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == IDLE && !an_ok) || changed) begin
      cnt <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; capture fires as CAPTURE is entered so the result
  // registers STABLE_CYCLES edges after the pair is first sampled
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (an_ok) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!an_ok) begin
          state_nxt = IDLE;
        end else if (cnt >= CNT_CAP) begin
          state_nxt = CAPTURE;
          capture   = 1'b1;
        end
      end
      CAPTURE: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (cnt != CNT_MAX) state_nxt = an_ok ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit store, status pulses and frame tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      upd        <= 1'b0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      if (capture) begin
        if (dec[4]) begin
          digits[{an_idx, 2'b00} +: 4] <= dec[3:0];
          digit_valid[an_idx]          <= 1'b1;
          upd                          <= 1'b1;
          upd_idx                      <= an_idx;
          if (seen_set == 8'hFF) begin
            frame_done <= 1'b1;
            seen       <= '0;
          end else begin
            seen <= seen_set;
          end
        end else begin
          digit_valid[an_idx] <= 1'b0;
          err                 <= 1'b1;
        end
      end
    end
  end

`ifdef SEG7_ERR_CNT_EN
  // Saturating error counter; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (capture && !dec[4] && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed bench with a run-length reference model.
// Honours SEG7_ERR_CNT_EN when the macro is defined for the build.
module tb_seg7_scan_capture;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  hex;
  logic [7:0]  AN;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        err;
  logic        frame_done;
`ifdef SEG7_ERR_CNT_EN
  logic        err_clr;
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  seg7_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hex(hex),
    .AN(AN),
`ifdef SEG7_ERR_CNT_EN
    .err_clr(err_clr),
    .err_cnt(err_cnt),
`endif
    .digits(digits),
    .digit_valid(digit_valid),
    .upd(upd),
    .upd_idx(upd_idx),
    .err(err),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Segment table, digit value -> active-low pattern
  function automatic logic [6:0] seg(input int v);
    case (v)
      0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
      4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
      8: seg = 7'h00;  9: seg = 7'h10; 10: seg = 7'h08; 11: seg = 7'h03;
      12: seg = 7'h46; 13: seg = 7'h21; 14: seg = 7'h06; default: seg = 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: capture once a pair has been sampled STABLE times in a row
  logic [14:0] m_last;
  int          m_run;
  bit          m_done;
  logic [31:0] m_digits;
  logic [7:0]  m_valid, m_seen;
  logic        m_upd, m_err, m_fd;
  logic [2:0]  m_idx;
  int          m_ecnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = {8'hFF, 7'h7F}; m_run = 0; m_done = 0;
      m_digits = '0; m_valid = '0; m_seen = '0;
      m_upd = 0; m_err = 0; m_fd = 0; m_idx = '0; m_ecnt = 0;
    end else begin
      automatic logic [7:0] an = m_last[14:7];
      automatic int pos = -1;
      automatic int val = -1;
      m_upd = 0; m_err = 0; m_fd = 0;
      if (m_run == STABLE && !m_done && $onehot(~an)) begin
        m_done = 1;
        for (int i = 0; i < 8; i++) if (!an[i]) pos = i;
        for (int v = 0; v < 16; v++) if (seg(v) == m_last[6:0]) val = v;
        if (val >= 0) begin
          m_digits[pos*4 +: 4] = 4'(val);
          m_valid[pos] = 1'b1;
          m_upd = 1; m_idx = 3'(pos);
          m_seen[pos] = 1'b1;
          if (m_seen == 8'hFF) begin m_fd = 1; m_seen = '0; end
        end else begin
          m_valid[pos] = 1'b0;
          m_err = 1;
        end
      end
`ifdef SEG7_ERR_CNT_EN
      if (err_clr) m_ecnt = 0;
      else if (m_err && m_ecnt < 255) m_ecnt++;
`endif
      if ({AN, hex} == m_last) begin
        if (m_run < STABLE) m_run++;
      end else begin
        m_last = {AN, hex}; m_run = 1; m_done = 0;
      end
    end
  end

  // Per-cycle comparison and event bookkeeping
  int cyc = 0, upd_n = 0, err_n = 0, fd_n = 0, last_upd_cyc = 0;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    chk("digits", digits, m_digits);
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("upd", 32'(upd), 32'(m_upd));
    chk("upd_idx", 32'(upd_idx), 32'(m_idx));
    chk("err", 32'(err), 32'(m_err));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("upd_err_excl", 32'(upd & err), 32'd0);
`ifdef SEG7_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif
    if (upd) begin upd_n++; last_upd_cyc = cyc; end
    if (err) err_n++;
    if (frame_done) fd_n++;
  end

  task automatic hold(input logic [7:0] an, input logic [6:0] hx, input int n);
    AN = an; hex = hx;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic scan(input int base);
    for (int i = 0; i < 8; i++) hold(~(8'b1 << i), seg(base + i), 6);
  endtask

  int c0, u0, e0, f0;

  initial begin
    rst_n = 1'b0; AN = 8'hFF; hex = 7'h7F;
`ifdef SEG7_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    hold(8'hFF, 7'h7F, 3);
    chk("rst_digits", digits, 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    rst_n = 1'b1;

    // Single digit: one update, 5 clocks after the change
    c0 = cyc; u0 = upd_n;
    hold(8'hFE, 7'h40, 10);
    chk("single_upd_cnt", 32'(upd_n - u0), 32'd1);
    chk("single_latency", 32'(last_upd_cyc - c0), 32'd5);
    chk("single_valid", 32'(digit_valid), 32'h01);

    // Reset mid-run with AN=FE held
    rst_n = 1'b0; #1;
    chk("midrst_outs", {digits[30:0], 1'b0} | 32'(digit_valid) | 32'(upd) | 32'(err) | 32'(frame_done) | 32'(upd_idx), 32'h0);
    hold(8'hFE, 7'h40, 2);
    rst_n = 1'b1;
    c0 = cyc; u0 = upd_n;
    hold(8'hFE, 7'h40, 10);
    chk("post_rst_upd_cnt", 32'(upd_n - u0), 32'd1);
    chk("post_rst_latency", 32'(last_upd_cyc - c0), 32'd5);

    // Glitch reject, then capture on position 2
    u0 = upd_n;
    hold(8'hFD, 7'h12, 3);
    chk("glitch_no_upd", 32'(upd_n - u0), 32'd0);
    hold(8'hFB, 7'h12, 6);
    chk("glitch_valid1", 32'(digit_valid[1]), 32'd0);
    chk("pos2_digit", 32'(digits[11:8]), 32'h5);
    chk("pos2_idx", 32'(upd_idx), 32'd2);

    // Two anodes low: ignored
    u0 = upd_n; e0 = err_n;
    hold(8'hFC, 7'h12, 20);
    chk("multi_an_upd", 32'(upd_n - u0), 32'd0);
    chk("multi_an_err", 32'(err_n - e0), 32'd0);

    // Digit 1 on position 0, then blank pattern on position 0
    hold(8'hFE, 7'h79, 6);
    chk("pos0_one", 32'(digits[3:0]), 32'h1);
    e0 = err_n; u0 = upd_n;
    hold(8'hFE, 7'h7F, 8);
    chk("bad_err_cnt", 32'(err_n - e0), 32'd1);
    chk("bad_no_upd", 32'(upd_n - u0), 32'd0);
    chk("bad_valid0", 32'(digit_valid[0]), 32'd0);
    chk("bad_keep_nib", 32'(digits[3:0]), 32'h1);
`ifdef SEG7_ERR_CNT_EN
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    err_clr = 1'b1;
    hold(8'hFE, 7'h7F, 1);
    err_clr = 1'b0;
    chk("err_cnt_clr", 32'(err_cnt), 32'd0);
`endif

    // Full frames
    rst_n = 1'b0;
    hold(8'hFF, 7'h7F, 1);
    rst_n = 1'b1;
    u0 = upd_n; f0 = fd_n;
    scan(0);
    chk("frame_upds", 32'(upd_n - u0), 32'd8);
    chk("frame_fd", 32'(fd_n - f0), 32'd1);
    chk("frame_digits", digits, 32'h76543210);
    chk("frame_valid", 32'(digit_valid), 32'hFF);
    scan(0);
    chk("frame2_fd", 32'(fd_n - f0), 32'd2);
    scan(8);
    chk("frame3_fd", 32'(fd_n - f0), 32'd3);
    chk("frame3_digits", digits, 32'hFEDCBA98);

    hold(8'hFF, 7'h7F, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
